// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an optional 2-entry skid.
// With the skid enabled, in_ready comes only from registered state and never from out_ready.
module pipe_stage_skid #(
   parameter int CTRL_W  = 3,
   parameter int DATA_W  = 69,
   parameter bit SKID_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              push, pop;

   assign out_valid = (state_q != EMPTY);

   if (SKID_EN) begin : g_skid
      assign in_ready = (state_q != TWO);
   end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;
   end

   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   assign out_ctrl = out_valid ? main_ctrl_q : '0;
   assign out_data = main_data_q;

   always_comb begin
      occupancy = 2'd0;
      case (state_q)
         ONE:     occupancy = 2'd1;
         TWO:     occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d     = ONE;
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
            end
         end
         ONE: begin
            if (push && pop) begin
               main_ctrl_d = in_ctrl;
               main_data_d = in_data;
            end else if (push) begin
               // Only reachable with the skid enabled: without it a push in ONE implies a pop.
               state_d     = TWO;
               skid_ctrl_d = in_ctrl;
               skid_data_d = in_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_d     = ONE;
               main_ctrl_d = skid_ctrl_q;
               main_data_d = skid_data_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Flush wins over everything; registers keep their contents so out_data holds.
      if (flush) begin
         state_d     = EMPTY;
         main_ctrl_d = main_ctrl_q;
         main_data_d = main_data_q;
         skid_ctrl_d = skid_ctrl_q;
         skid_data_d = skid_data_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= EMPTY;
         main_ctrl_q <= '0;
         main_data_q <= '0;
         skid_ctrl_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_ctrl_q <= main_ctrl_d;
         main_data_q <= main_data_d;
         skid_ctrl_q <= skid_ctrl_d;
         skid_data_q <= skid_data_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid and no-skid instances share one stimulus stream and
// are compared every cycle against queue models, plus directed literal expectations.
module tb_pipe_stage_skid;

   localparam int CW = 3;
   localparam int DW = 69;

   logic          clk;
   logic          rstn;
   logic          flush;
   logic          in_valid;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          out_ready;

   logic          u1_in_ready, u1_out_valid;
   logic [CW-1:0] u1_out_ctrl;
   logic [DW-1:0] u1_out_data;
   logic [1:0]    u1_occ;
   logic          u0_in_ready, u0_out_valid;
   logic [CW-1:0] u0_out_ctrl;
   logic [DW-1:0] u0_out_data;
   logic [1:0]    u0_occ;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b1)) u1 (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(u1_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(u1_out_valid), .out_ready(out_ready), .out_ctrl(u1_out_ctrl),
      .out_data(u1_out_data), .occupancy(u1_occ)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID_EN(1'b0)) u0 (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_valid(in_valid), .in_ready(u0_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(u0_out_valid), .out_ready(out_ready), .out_ctrl(u0_out_ctrl),
      .out_data(u0_out_data), .occupancy(u0_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: each stage is a bounded FIFO; head is what out_* shows.
   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          q1[$];
   ent_t          q0[$];
   logic [DW-1:0] h1, h0;
   bit            push1, pop1, push0, pop0;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         q1.delete(); q0.delete();
         h1 = '0; h0 = '0;
      end else begin
         pop1  = (q1.size() > 0) && out_ready;
         push1 = in_valid && (q1.size() < 2);
         pop0  = (q0.size() > 0) && out_ready;
         push0 = in_valid && ((q0.size() == 0) || out_ready);
         if (q1.size() > 0) h1 = q1[0].d;
         if (q0.size() > 0) h0 = q0[0].d;
         if (flush) begin
            q1.delete(); q0.delete();
         end else begin
            if (pop1) void'(q1.pop_front());
            if (push1) q1.push_back(ent_t'{in_ctrl, in_data});
            if (pop0) void'(q0.pop_front());
            if (push0) q0.push_back(ent_t'{in_ctrl, in_data});
         end
      end
   end

   always @(negedge clk) begin
      chk("u1_out_valid", 128'(u1_out_valid), 128'(q1.size() > 0));
      chk("u1_out_ctrl", 128'(u1_out_ctrl), (q1.size() > 0) ? 128'(q1[0].c) : 128'(0));
      chk("u1_out_data", 128'(u1_out_data), (q1.size() > 0) ? 128'(q1[0].d) : 128'(h1));
      chk("u1_occupancy", 128'(u1_occ), 128'(q1.size()));
      chk("u1_in_ready", 128'(u1_in_ready), 128'(q1.size() < 2));
      chk("u0_out_valid", 128'(u0_out_valid), 128'(q0.size() > 0));
      chk("u0_out_ctrl", 128'(u0_out_ctrl), (q0.size() > 0) ? 128'(q0[0].c) : 128'(0));
      chk("u0_out_data", 128'(u0_out_data), (q0.size() > 0) ? 128'(q0[0].d) : 128'(h0));
      chk("u0_occupancy", 128'(u0_occ), 128'(q0.size()));
      chk("u0_in_ready", 128'(u0_in_ready), 128'((q0.size() == 0) || out_ready));
   end

   // Returns just after the falling edge, so one rising edge has passed.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rstn = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 3'b011;
      in_data = DW'(8'h11); out_ready = 1'b1;
      cyc(); cyc();
      chk("rst_out_valid", 128'(u1_out_valid), 128'(0));
      chk("rst_out_ctrl", 128'(u1_out_ctrl), 128'(0));
      chk("rst_occ", 128'(u1_occ), 128'(0));
      chk("rst_in_ready", 128'(u1_in_ready), 128'(1));
      chk("rst_out_data", 128'(u1_out_data), 128'(0));
      rstn = 1'b1;
      cyc();
      chk("first_push_data", 128'(u1_out_data), 128'(8'h11));
      chk("first_push_valid", 128'(u1_out_valid), 128'(1));
      in_valid = 1'b0;
      cyc(); cyc();

      // Streaming at full rate
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i);
         cyc();
         chk("stream_data", 128'(u1_out_data), 128'(i));
         chk("stream_valid", 128'(u1_out_valid), 128'(1));
         chk("stream_ready", 128'(u1_in_ready), 128'(1));
      end
      in_valid = 1'b0;
      cyc();

      // Backpressure fills the skid, then drains in order
      out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'hA0);
      cyc();
      chk("ns_held_ready", 128'(u0_in_ready), 128'(0));
      chk("ns_held_occ", 128'(u0_occ), 128'(1));
      in_data = DW'(8'hB0);
      cyc();
      chk("bp_occ2", 128'(u1_occ), 128'(2));
      chk("bp_in_ready", 128'(u1_in_ready), 128'(0));
      chk("bp_head_a", 128'(u1_out_data), 128'(8'hA0));
      chk("model_occ2", 128'(q1.size()), 128'(2));
      in_data = DW'(8'hC0);
      cyc();
      chk("bp_hold_occ", 128'(u1_occ), 128'(2));
      chk("bp_hold_a", 128'(u1_out_data), 128'(8'hA0));
      out_ready = 1'b1;
      #1;
      chk("ns_comb_ready", 128'(u0_in_ready), 128'(1));
      cyc();
      chk("bp_drain_b", 128'(u1_out_data), 128'(8'hB0));
      chk("bp_drain_occ", 128'(u1_occ), 128'(1));
      chk("ns_replaced_c", 128'(u0_out_data), 128'(8'hC0));
      cyc();
      chk("bp_drain_c", 128'(u1_out_data), 128'(8'hC0));
      in_valid = 1'b0;
      cyc();
      chk("bp_empty", 128'(u1_out_valid), 128'(0));

      // Flush while full with a push offered
      out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(8'h21);
      cyc();
      in_data = DW'(8'h22);
      cyc();
      in_data = DW'(8'h55); flush = 1'b1;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_out_valid", 128'(u1_out_valid), 128'(0));
      chk("fl_occ", 128'(u1_occ), 128'(0));
      chk("fl_in_ready", 128'(u1_in_ready), 128'(1));
      chk("fl_out_ctrl", 128'(u1_out_ctrl), 128'(0));
      chk("fl_data_kept", 128'(u1_out_data), 128'(8'h21));
      chk("model_flushed", 128'(q1.size()), 128'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("fl_no_55", 128'(u1_out_valid), 128'(0));
      end

      // Bubbles zero the control field
      in_valid = 1'b1; in_ctrl = 3'b101; in_data = DW'(8'h77);
      cyc();
      chk("bub_ctrl_live", 128'(u1_out_ctrl), 128'(3'b101));
      in_valid = 1'b0; in_ctrl = 3'b111;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bub_ctrl_u1", 128'(u1_out_ctrl), 128'(0));
         chk("bub_ctrl_u0", 128'(u0_out_ctrl), 128'(0));
      end

      // Random traffic with occasional flush and one mid-run async reset
      for (int n = 0; n < 1500; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         in_ctrl   = CW'($urandom);
         in_data   = DW'({$urandom, $urandom, $urandom});
         if (n == 700) rstn = 1'b0;
         if (n == 703) rstn = 1'b1;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
